// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: widths, opcodes, FSM states.
// Macro CPU_MPY_EN enables the signed multiplier (MPY); without it MPY decodes as NOP.
package cpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_MPY    = 8'h08;
  localparam logic [7:0] OP_AND    = 8'h0A;
  localparam logic [7:0] OP_OR     = 8'h0B;
  localparam logic [7:0] OP_NOT    = 8'h0C;
  localparam logic [7:0] OP_SHIFTR = 8'h0D;
  localparam logic [7:0] OP_SHIFTL = 8'h0E;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  // Opcodes that read M[X] and therefore need the extra write-back cycle.
  function automatic logic needsOperand(input logic [7:0] op);
    case (op)
      OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: needsOperand = 1'b1;
`ifdef CPU_MPY_EN
      OP_MPY: needsOperand = 1'b1;
`endif
      default: needsOperand = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational datapath: computes the new accumulator and MR for one opcode.
// Macro CPU_MPY_EN adds the signed multiplier; otherwise MR passes through unchanged.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] operand_i,
  input  logic [7:0]        opcode_i,
  input  logic [3:0]        shamt_i,
  input  logic [DATA_W-1:0] mr_i,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] mr_o
);

`ifdef CPU_MPY_EN
  logic signed [2*DATA_W-1:0] accExt;
  logic signed [2*DATA_W-1:0] operandExt;
  logic signed [2*DATA_W-1:0] product;

  // Both factors are sign-extended so the full-width product is exact.
  assign accExt     = {{DATA_W{acc_i[DATA_W-1]}}, acc_i};
  assign operandExt = {{DATA_W{operand_i[DATA_W-1]}}, operand_i};
  assign product    = accExt * operandExt;
`endif

  always_comb begin
    result_o = acc_i;
    mr_o     = mr_i;
    case (opcode_i)
      OP_LOAD:   result_o = operand_i;
      OP_ADD:    result_o = acc_i + operand_i;
      OP_SUB:    result_o = acc_i - operand_i;
      OP_AND:    result_o = acc_i & operand_i;
      OP_OR:     result_o = acc_i | operand_i;
      OP_NOT:    result_o = ~operand_i;
      OP_SHIFTR: result_o = acc_i >> shamt_i;
      OP_SHIFTL: result_o = acc_i << shamt_i;
`ifdef CPU_MPY_EN
      OP_MPY: begin
        result_o = product[DATA_W-1:0];
        mr_o     = product[2*DATA_W-1:DATA_W];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_top.sv
// Accumulator CPU: FETCH/DECODE/EXEC/WB sequencer against a 1-cycle-latency memory.
// Macro CPU_MPY_EN enables MPY (see cpu_alu); the default build treats opcode 08 as NOP.
module cpu_top
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              wea
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] mr_q;
  logic              wea_q;

  logic [7:0]        opcode;
  logic [ADDR_W-1:0] pc_d;
  logic [DATA_W-1:0] aluResult;
  logic [DATA_W-1:0] aluMr;

  assign opcode   = ir_q[15:8];
  assign address  = addr_q;
  assign data_out = acc_q;
  assign wea      = wea_q;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .acc_i    (acc_q),
    .operand_i(data_in),
    .opcode_i (opcode),
    .shamt_i  (ir_q[3:0]),
    .mr_i     (mr_q),
    .result_o (aluResult),
    .mr_o     (aluMr)
  );

  // PC after EXEC: pc_q already points past the current instruction.
  always_comb begin
    pc_d = pc_q;
    if (opcode == OP_JMP || (opcode == OP_JMPGEZ && !acc_q[DATA_W-1])) begin
      pc_d = ADDR_W'(ir_q[7:0]);
    end
  end

  // Address and wea are registered one state ahead so they are glitch-free outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      addr_q  <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      mr_q    <= '0;
      wea_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          ir_q    <= data_in;
          pc_q    <= pc_q + 1'b1;
          addr_q  <= ADDR_W'(data_in[7:0]);
          wea_q   <= (data_in[15:8] == OP_STORE);
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          wea_q <= 1'b0;
          if (opcode == OP_HALT) begin
            state_q <= S_HALT;
          end else if (needsOperand(opcode)) begin
            state_q <= S_WB;
          end else begin
            state_q <= S_FETCH;
            pc_q    <= pc_d;
            addr_q  <= pc_d;
            if (opcode == OP_SHIFTR || opcode == OP_SHIFTL) begin
              acc_q <= aluResult;
            end
          end
        end
        S_WB: begin
          acc_q   <= aluResult;
          mr_q    <= aluMr;
          addr_q  <= pc_q;
          state_q <= S_FETCH;
        end
        S_HALT: ;
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_top.sv
// Self-checking bench for cpu_top: directed programs plus random programs against an ISA-level model.
`timescale 1ns/1ps
module tb_cpu_top;

  localparam logic [7:0] STORE = 8'h01, LOAD = 8'h02, ADD = 8'h03, SUB = 8'h04, JMPGEZ = 8'h05,
                         JMP = 8'h06, HALT = 8'h07, MPY = 8'h08, AND_ = 8'h0A, OR_ = 8'h0B,
                         NOT_ = 8'h0C, SHR = 8'h0D, SHL = 8'h0E;

`ifdef CPU_MPY_EN
  localparam logic [15:0] EXP_MPY = 16'h0006;
`else
  localparam logic [15:0] EXP_MPY = 16'h0002;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] data_in;
  logic [7:0]  address;
  logic [15:0] data_out;
  logic        wea;

  cpu_top #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .address (address),
    .data_out(data_out),
    .wea     (wea)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int data; int cyc;} wr_t;

  logic [15:0] mem [256];
  logic [15:0] img [256];
  logic [15:0] mdl [256];
  logic        tbWe = 1'b0;
  logic [7:0]  tbAddr = '0;
  logic [15:0] tbData = '0;
  int          edgeCnt;
  wr_t         wrLog[$];
  wr_t         expWr[$];
  logic [15:0] mAcc;
  logic [7:0]  mPc;
  int          mEdges;
  bit          mHalted;
  int          mHaltX;
  int          nCmp = 0;
  int          nFail = 0;

  // Synchronous memory with one-cycle read latency; the bench preloads it during reset.
  always @(posedge clk) begin
    if (tbWe) mem[tbAddr] <= tbData;
    else if (wea) mem[address] <= data_out;
    data_in <= mem[address];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edgeCnt <= 0;
    else edgeCnt <= edgeCnt + 1;
  end

  // A high wea seen at a falling edge means a write on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) wrLog.delete();
    else if (wea) wrLog.push_back('{int'(address), int'(data_out), edgeCnt + 1});
  end

  task automatic clearImg();
    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
  endtask

  task automatic putI(input int a, input logic [7:0] op, input logic [7:0] x);
    img[a] = {op, x};
  endtask

  task automatic loadAndReset();
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      tbWe = 1'b1; tbAddr = i[7:0]; tbData = img[i];
    end
    @(negedge clk);
    tbWe = 1'b0; rst_n = 1'b1;
  endtask

  task automatic runDut(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Instruction-level model: executes whole instructions and tallies cycles per instruction class.
  task automatic runModel(input int maxInstr);
    logic [7:0]  op, x;
    logic [15:0] m;
    int          prod;
    for (int i = 0; i < 256; i++) mdl[i] = img[i];
    mAcc = '0; mPc = '0; mEdges = 0; mHalted = 0; mHaltX = 0;
    expWr.delete();
    for (int n = 0; n < maxInstr && !mHalted; n++) begin
      op = mdl[mPc][15:8];
      x  = mdl[mPc][7:0];
      m  = mdl[x];
      mPc = mPc + 8'd1;
      case (op)
        STORE:  begin expWr.push_back('{int'(x), int'(mAcc), mEdges + 3}); mdl[x] = mAcc; mEdges += 3; end
        LOAD:   begin mAcc = m; mEdges += 4; end
        ADD:    begin mAcc = mAcc + m; mEdges += 4; end
        SUB:    begin mAcc = mAcc - m; mEdges += 4; end
        AND_:   begin mAcc = mAcc & m; mEdges += 4; end
        OR_:    begin mAcc = mAcc | m; mEdges += 4; end
        NOT_:   begin mAcc = ~m; mEdges += 4; end
        SHR:    begin mAcc = mAcc >> x[3:0]; mEdges += 3; end
        SHL:    begin mAcc = mAcc << x[3:0]; mEdges += 3; end
        JMP:    begin mPc = x; mEdges += 3; end
        JMPGEZ: begin if (!mAcc[15]) mPc = x; mEdges += 3; end
        HALT:   begin mHalted = 1; mHaltX = int'(x); mEdges += 3; end
`ifdef CPU_MPY_EN
        MPY: begin
          prod = int'($signed(mAcc)) * int'($signed(m));
          mAcc = prod[15:0];
          mEdges += 4;
        end
`endif
        default: mEdges += 3;
      endcase
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    nCmp++; if (address !== 8'h00) begin nFail++; $display("[TB] FAIL reset_address got=%h want=00", address); end
    nCmp++; if (data_out !== 16'h0000) begin nFail++; $display("[TB] FAIL reset_data_out got=%h want=0000", data_out); end
    nCmp++; if (wea !== 1'b0) begin nFail++; $display("[TB] FAIL reset_wea got=%b want=0", wea); end
    clearImg();
    img[130] = 16'h1234;
    putI(0, STORE, 8'd130);
    putI(1, HALT, 8'd0);
    loadAndReset();
    nCmp++; if (address !== 8'h00 || wea !== 1'b0) begin nFail++; $display("[TB] FAIL reset_release got=%h/%b want=00/0", address, wea); end
    runDut(6);
    nCmp++; if (wrLog.size() != 1) begin nFail++; $display("[TB] FAIL first_fetch_writes got=%0d want=1", wrLog.size()); end
    else begin
      nCmp++; if (wrLog[0].cyc != 3 || wrLog[0].addr != 130) begin nFail++; $display("[TB] FAIL first_fetch_timing got=edge%0d@%0d want=edge3@130", wrLog[0].cyc, wrLog[0].addr); end
    end
    nCmp++; if (mem[130] !== 16'h0000) begin nFail++; $display("[TB] FAIL first_store got=%h want=0000", mem[130]); end
  endtask

  task automatic test_arith();
    clearImg();
    img[50] = 16'd1; img[51] = 16'd2;
    putI(0, LOAD, 50); putI(1, STORE, 100); putI(2, ADD, 51); putI(3, STORE, 101);
    putI(4, SUB, 50); putI(5, STORE, 102); putI(6, HALT, 0);
    runModel(50);
    loadAndReset();
    runDut(mEdges + 2);
    nCmp++; if (mem[100] !== 16'd1) begin nFail++; $display("[TB] FAIL arith_load got=%h want=0001", mem[100]); end
    nCmp++; if (mem[101] !== 16'd3) begin nFail++; $display("[TB] FAIL arith_add got=%h want=0003", mem[101]); end
    nCmp++; if (mem[102] !== 16'd2) begin nFail++; $display("[TB] FAIL arith_sub got=%h want=0002", mem[102]); end
    nCmp++; if (wrLog.size() != 3) begin nFail++; $display("[TB] FAIL arith_writes got=%0d want=3", wrLog.size()); end
    else begin
      nCmp++; if (wrLog[0].cyc != 7) begin nFail++; $display("[TB] FAIL arith_store_edge got=%0d want=7", wrLog[0].cyc); end
    end
  endtask

  task automatic test_logic();
    clearImg();
    img[50] = 16'd1; img[51] = 16'd2; img[52] = 16'd3;
    putI(0, LOAD, 51); putI(1, MPY, 52); putI(2, STORE, 103);
    putI(3, LOAD, 50); putI(4, AND_, 51); putI(5, STORE, 104);
    putI(6, LOAD, 50); putI(7, OR_, 51); putI(8, STORE, 105);
    putI(9, NOT_, 50); putI(10, STORE, 106); putI(11, HALT, 0);
    runModel(50);
    loadAndReset();
    runDut(mEdges + 2);
    nCmp++; if (mem[103] !== EXP_MPY) begin nFail++; $display("[TB] FAIL logic_mpy got=%h want=%h", mem[103], EXP_MPY); end
    nCmp++; if (mem[104] !== 16'h0000) begin nFail++; $display("[TB] FAIL logic_and got=%h want=0000", mem[104]); end
    nCmp++; if (mem[105] !== 16'h0003) begin nFail++; $display("[TB] FAIL logic_or got=%h want=0003", mem[105]); end
    nCmp++; if (mem[106] !== 16'hFFFE) begin nFail++; $display("[TB] FAIL logic_not got=%h want=fffe", mem[106]); end
  endtask

  task automatic test_shift();
    clearImg();
    img[54] = 16'd8;
    putI(0, LOAD, 54); putI(1, SHR, 1); putI(2, STORE, 107);
    putI(3, LOAD, 54); putI(4, SHL, 1); putI(5, STORE, 108);
    putI(6, SHR, 8'h10); putI(7, 8'h09, 50); putI(8, 8'hFF, 51); putI(9, STORE, 109); putI(10, HALT, 0);
    runModel(50);
    loadAndReset();
    runDut(mEdges + 2);
    nCmp++; if (mem[107] !== 16'h0004) begin nFail++; $display("[TB] FAIL shift_right got=%h want=0004", mem[107]); end
    nCmp++; if (mem[108] !== 16'h0010) begin nFail++; $display("[TB] FAIL shift_left got=%h want=0010", mem[108]); end
    nCmp++; if (mem[109] !== 16'h0010) begin nFail++; $display("[TB] FAIL shift_zero_nop got=%h want=0010", mem[109]); end
  endtask

  task automatic test_branch_loop();
    clearImg();
    img[50] = 16'd1; img[52] = 16'd3; img[54] = 16'd8;
    putI(0, LOAD, 52); putI(1, SUB, 50); putI(2, JMPGEZ, 1); putI(3, STORE, 115);
    putI(4, JMP, 6); putI(5, STORE, 114); putI(6, LOAD, 54); putI(7, STORE, 110); putI(8, HALT, 8'h77);
    loadAndReset();
    runDut(48);
    nCmp++; if (mem[115] !== 16'hFFFF) begin nFail++; $display("[TB] FAIL loop_exit_acc got=%h want=ffff", mem[115]); end
    nCmp++; if (mem[114] !== 16'h0000) begin nFail++; $display("[TB] FAIL loop_skipped_store got=%h want=0000", mem[114]); end
    nCmp++; if (mem[110] !== 16'h0008) begin nFail++; $display("[TB] FAIL loop_after got=%h want=0008", mem[110]); end
    nCmp++; if (wrLog.size() != 2) begin nFail++; $display("[TB] FAIL loop_writes got=%0d want=2", wrLog.size()); end
    else begin
      nCmp++; if (wrLog[0].cyc != 35 || wrLog[1].cyc != 45) begin nFail++; $display("[TB] FAIL loop_timing got=%0d,%0d want=35,45", wrLog[0].cyc, wrLog[1].cyc); end
    end
    nCmp++; if (address !== 8'h77) begin nFail++; $display("[TB] FAIL loop_halt_addr got=%h want=77", address); end
  endtask

  task automatic test_jump_halt();
    logic [7:0] frozen;
    clearImg();
    img[53] = 16'h00F4; img[54] = 16'd8; img[55] = 16'hFFF0;
    putI(0, LOAD, 55); putI(1, JMPGEZ, 40); putI(2, LOAD, 54); putI(3, STORE, 111); putI(4, JMP, 40);
    putI(40, LOAD, 53); putI(41, STORE, 112); putI(42, HALT, 8'h66);
    loadAndReset();
    runDut(27);
    nCmp++; if (mem[111] !== 16'h0008) begin nFail++; $display("[TB] FAIL jmpgez_not_taken got=%h want=0008", mem[111]); end
    nCmp++; if (mem[112] !== 16'h00F4) begin nFail++; $display("[TB] FAIL jmp_target got=%h want=00f4", mem[112]); end
    nCmp++; if (address !== 8'h66) begin nFail++; $display("[TB] FAIL halt_addr got=%h want=66", address); end
    frozen = address;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nCmp++; if (address !== frozen || wea !== 1'b0 || data_out !== 16'h00F4) begin
        nFail++; $display("[TB] FAIL halt_frozen got=%h/%b/%h want=%h/0/00f4", address, wea, data_out, frozen);
      end
    end
    nCmp++; if (wrLog.size() != 2) begin nFail++; $display("[TB] FAIL halt_writes got=%0d want=2", wrLog.size()); end
  endtask

  task automatic test_pc_wrap();
    clearImg();
    img[54] = 16'd8;
    putI(0, JMP, 8'hFD); putI(8'hFD, LOAD, 54); putI(8'hFE, STORE, 121); putI(8'hFF, 8'h00, 0);
    loadAndReset();
    runDut(13);
    nCmp++; if (address !== 8'h00) begin nFail++; $display("[TB] FAIL pc_wrap got=%h want=00", address); end
    nCmp++; if (mem[121] !== 16'h0008) begin nFail++; $display("[TB] FAIL pc_wrap_store got=%h want=0008", mem[121]); end
  endtask

  task automatic test_mid_reset();
    clearImg();
    img[54] = 16'd8;
    putI(0, LOAD, 54); putI(1, STORE, 120); putI(2, HALT, 0);
    loadAndReset();
    runDut(6);
    nCmp++; if (wea !== 1'b1) begin nFail++; $display("[TB] FAIL midreset_in_store got=%b want=1", wea); end
    #1 rst_n = 1'b0;
    #1;
    nCmp++; if (address !== 8'h00 || data_out !== 16'h0000 || wea !== 1'b0) begin
      nFail++; $display("[TB] FAIL midreset_outputs got=%h/%h/%b want=00/0000/0", address, data_out, wea);
    end
    repeat (3) @(negedge clk);
    nCmp++; if (mem[120] !== 16'h0000) begin nFail++; $display("[TB] FAIL midreset_no_write got=%h want=0000", mem[120]); end
    rst_n = 1'b1;
    runDut(10);
    nCmp++; if (wrLog.size() != 1) begin nFail++; $display("[TB] FAIL midreset_restart_writes got=%0d want=1", wrLog.size()); end
    else begin
      nCmp++; if (wrLog[0].cyc != 7) begin nFail++; $display("[TB] FAIL midreset_restart_edge got=%0d want=7", wrLog[0].cyc); end
    end
    nCmp++; if (mem[120] !== 16'h0008) begin nFail++; $display("[TB] FAIL midreset_restart_store got=%h want=0008", mem[120]); end
  endtask

  task automatic test_random();
    int r, bad;
    logic [7:0] op, x;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 256; i++) img[i] = 16'($urandom);
      for (int a = 0; a < 24; a++) begin
        r = $urandom_range(0, 19);
        op = (r <= 14) ? 8'(r) : 8'($urandom_range(15, 255));
        x = (op == JMP || op == JMPGEZ) ? 8'($urandom_range(0, 23)) : 8'($urandom_range(0, 255));
        putI(a, op, x);
      end
      runModel(60);
      loadAndReset();
      runDut(mEdges);
      nCmp++; if (data_out !== mAcc) begin nFail++; $display("[TB] FAIL rand%0d_acc got=%h want=%h", p, data_out, mAcc); end
      nCmp++; if (int'(address) != (mHalted ? mHaltX : int'(mPc)) || wea !== 1'b0) begin
        nFail++; $display("[TB] FAIL rand%0d_addr got=%h/%b want=%h/0", p, address, wea, mHalted ? mHaltX : int'(mPc));
      end
      nCmp++;
      if (wrLog.size() != expWr.size()) begin
        nFail++; $display("[TB] FAIL rand%0d_write_count got=%0d want=%0d", p, wrLog.size(), expWr.size());
      end else begin
        bad = 0;
        foreach (expWr[i])
          if (wrLog[i].addr != expWr[i].addr || wrLog[i].data != expWr[i].data || wrLog[i].cyc != expWr[i].cyc) bad++;
        if (bad != 0) begin nFail++; $display("[TB] FAIL rand%0d_write_trace got=%0d differing want=0", p, bad); end
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== mdl[i]) bad++;
      nCmp++; if (bad != 0) begin nFail++; $display("[TB] FAIL rand%0d_memory got=%0d differing words want=0", p, bad); end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_branch_loop();
    test_jump_halt();
    test_pc_wrap();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
